memif_arb: RTL
==============

MEMIF_ARB -- requirements
Module: memif_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of all mi address buses.
REQ-002 Parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = port 1 always wins a tie.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 mi0_addr/mi1_addr  in  ADDR_WIDTH  requester command address.
REQ-006 mi0_len/mi1_len  in  7  burst length; beats = len+1.
REQ-007 mi0_rw/mi1_rw  in  1  1 = read, 0 = write.
REQ-008 mi0_valid/mi1_valid  in  1  command request; held until ready.
REQ-009 mi0_ready/mi1_ready  out  1  command accepted for that port.
REQ-010 mi0_wdata/mi1_wdata  in  32  write data; mi0_wack/mi1_wack  out  1  per-port write-beat ack.
REQ-011 mi0_rdata/mi1_rdata  out  32  read data; mi0_rstb/mi1_rstb  out  1  per-port read-beat strobe.
REQ-012 mi_addr, mi_len, mi_rw, mi_valid  out  ADDR_WIDTH/7/1/1  command to memory controller; mi_ready  in  1.
REQ-013 mi_wdata  out  32; mi_wack  in  1; mi_rdata  in  32; mi_rstb  in  1  memory-side data path.

Function
REQ-014 FSM states IDLE, CMD, DATA; one transaction outstanding at a time.
REQ-015 IDLE: if any mi*_valid, register grant and go to CMD next cycle; else stay.
REQ-016 Tie, FIXED_PRIO=0: grant the port not granted last; single requester always granted.
REQ-017 Tie, FIXED_PRIO=1: grant port 1.
REQ-018 CMD: mi_addr/len/rw/valid driven combinationally from granted port; mi_valid = granted valid.
REQ-019 CMD: granted mi*_ready = mi_ready & mi_valid; non-granted ready = 0 at all times.
REQ-020 Handshake (mi_valid & mi_ready) in CMD: latch len and rw, clear beat counter, go to DATA.
REQ-021 CMD with granted valid low (requester withdrew): return to IDLE, no beats, last-grant unchanged.
REQ-022 DATA: count mi_wack if latched rw=0, mi_rstb if rw=1; other strobe ignored.
REQ-023 DATA: strobe with counter == latched len is final beat; go to IDLE next cycle, update last-grant.
REQ-024 7-bit counter; len=127 gives 128 beats, no wrap before final beat.
REQ-025 mi_wdata = granted port's wdata in CMD and DATA, 0 in IDLE.
REQ-026 mi*_wack/mi*_rstb = memory strobe AND (state DATA) AND (grant == port); others 0.
REQ-027 mi0_rdata and mi1_rdata = mi_rdata unconditionally (broadcast).
REQ-028 Strobes in IDLE or CMD are dropped and not counted.
REQ-029 Command latency: valid asserted in IDLE -> mi_valid high next cycle; min 1 IDLE cycle between bursts.

Reset
REQ-030 On rst: state IDLE, grant port 0, last-grant = port 1, counter 0.
REQ-031 During and after rst: mi_valid, mi0_ready, mi1_ready, all wack/rstb outputs = 0.
REQ-032 rst mid-burst aborts the transaction at the next edge; remaining strobes dropped per REQ-028.

Structure
REQ-033 Single flat module, no sub-modules; FSM encodings are local constants.
REQ-034 No shared package; mi_* widths match memtest and hdmi_out ports.

Verification
REQ-035 Port 0 only, write len=3 -> mi_valid high 1 cycle after mi0_valid; 4 mi0_wack, 0 mi1_wack; IDLE after 4th.
REQ-036 Both valid from reset, FIXED_PRIO=0, reads len=1 -> port 0 served first, then port 1; alternation over 4 bursts.
REQ-037 Both valid, FIXED_PRIO=1 -> port 1 granted on every tie; port 0 only when port 1 idle.
REQ-038 Port 1 read len=127 -> exactly 128 mi1_rstb, mi_rdata seen on mi1_rdata each beat, no mi0_rstb.
REQ-039 Stray mi_wack during read burst, stray mi_rstb in IDLE -> neither counted nor forwarded.
REQ-040 rst asserted at beat 2 of len=7 write -> next cycle IDLE, all outputs 0; new port 0 request then served normally.

Source files
------------

// File: rtl/memif_arb.sv
// Two-port command/burst arbiter in front of a single memory controller port.
// One transaction is outstanding at a time; beats are counted from the memory-side strobes.
module memif_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mi0_addr,
  input  logic [6:0]            mi0_len,
  input  logic                  mi0_rw,
  input  logic                  mi0_valid,
  output logic                  mi0_ready,
  input  logic [31:0]           mi0_wdata,
  output logic                  mi0_wack,
  output logic [31:0]           mi0_rdata,
  output logic                  mi0_rstb,
  input  logic [ADDR_WIDTH-1:0] mi1_addr,
  input  logic [6:0]            mi1_len,
  input  logic                  mi1_rw,
  input  logic                  mi1_valid,
  output logic                  mi1_ready,
  input  logic [31:0]           mi1_wdata,
  output logic                  mi1_wack,
  output logic [31:0]           mi1_rdata,
  output logic                  mi1_rstb,
  output logic [ADDR_WIDTH-1:0] mi_addr,
  output logic [6:0]            mi_len,
  output logic                  mi_rw,
  output logic                  mi_valid,
  input  logic                  mi_ready,
  output logic [31:0]           mi_wdata,
  input  logic                  mi_wack,
  input  logic [31:0]           mi_rdata,
  input  logic                  mi_rstb
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic       rw_q, rw_d;
  logic [6:0] len_q, len_d;
  logic [6:0] cnt_q, cnt_d;

  logic       g_valid;
  logic [6:0] g_len;
  logic       g_rw;
  logic       beat;

  always_comb begin
    g_valid = grant_q ? mi1_valid : mi0_valid;
    g_len   = grant_q ? mi1_len   : mi0_len;
    g_rw    = grant_q ? mi1_rw    : mi0_rw;
    // only the strobe matching the latched direction advances the burst
    beat    = (state_q == ST_DATA) && (rw_q ? mi_rstb : mi_wack);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rw_d    = rw_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mi0_valid || mi1_valid) begin
          if (mi0_valid && mi1_valid) begin
            grant_d = FIXED_PRIO ? 1'b1 : ~last_q;
          end else begin
            grant_d = mi1_valid;
          end
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (!g_valid) begin
          state_d = ST_IDLE;
        end else if (mi_ready) begin
          len_d   = g_len;
          rw_d    = g_rw;
          cnt_d   = 7'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat) begin
          if (cnt_q == len_q) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      rw_q    <= 1'b0;
      len_q   <= 7'd0;
      cnt_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are held quiet while rst is high, even before the first reset edge.
  always_comb begin
    mi_addr   = '0;
    mi_len    = 7'd0;
    mi_rw     = 1'b0;
    mi_valid  = 1'b0;
    mi0_ready = 1'b0;
    mi1_ready = 1'b0;
    mi_wdata  = 32'd0;
    mi0_wack  = 1'b0;
    mi1_wack  = 1'b0;
    mi0_rstb  = 1'b0;
    mi1_rstb  = 1'b0;
    mi0_rdata = mi_rdata;
    mi1_rdata = mi_rdata;
    if (!rst) begin
      if (state_q == ST_CMD) begin
        mi_addr   = grant_q ? mi1_addr : mi0_addr;
        mi_len    = g_len;
        mi_rw     = g_rw;
        mi_valid  = g_valid;
        mi0_ready = !grant_q && g_valid && mi_ready;
        mi1_ready =  grant_q && g_valid && mi_ready;
      end
      if (state_q != ST_IDLE) begin
        mi_wdata = grant_q ? mi1_wdata : mi0_wdata;
      end
      if (state_q == ST_DATA) begin
        mi0_wack = mi_wack && !rw_q && !grant_q;
        mi1_wack = mi_wack && !rw_q &&  grant_q;
        mi0_rstb = mi_rstb &&  rw_q && !grant_q;
        mi1_rstb = mi_rstb &&  rw_q &&  grant_q;
      end
    end
  end

endmodule
